// File: rtl/ps2_key_source_pkg.sv
// Shared scancode, decoder-state and ASCII constants for the PS/2 keyboard front end,
// plus the set-2 to ASCII lookup used by the decoder.
package ps2_key_source_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BREAK   = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_BKSP  = 8'h08;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LC_A  = 8'h61;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_CASE  = 8'h20;

    typedef struct packed {
        logic       hit;
        logic [7:0] ch;
    } map_t;

    function automatic map_t ascii_map(input logic [7:0] code, input logic shift);
        map_t       r;
        logic       letter;
        logic [4:0] li;
        logic [3:0] di;
        logic       digit;
        r.hit  = 1'b1;
        r.ch   = 8'h00;
        letter = 1'b1;
        digit  = 1'b0;
        li     = 5'd0;
        di     = 4'd0;
        case (code)
            8'h1C: li = 5'd0;
            8'h32: li = 5'd1;
            8'h21: li = 5'd2;
            8'h23: li = 5'd3;
            8'h24: li = 5'd4;
            8'h2B: li = 5'd5;
            8'h34: li = 5'd6;
            8'h33: li = 5'd7;
            8'h43: li = 5'd8;
            8'h3B: li = 5'd9;
            8'h42: li = 5'd10;
            8'h4B: li = 5'd11;
            8'h3A: li = 5'd12;
            8'h31: li = 5'd13;
            8'h44: li = 5'd14;
            8'h4D: li = 5'd15;
            8'h15: li = 5'd16;
            8'h2D: li = 5'd17;
            8'h1B: li = 5'd18;
            8'h2C: li = 5'd19;
            8'h3C: li = 5'd20;
            8'h2A: li = 5'd21;
            8'h1D: li = 5'd22;
            8'h22: li = 5'd23;
            8'h35: li = 5'd24;
            8'h1A: li = 5'd25;
            default: letter = 1'b0;
        endcase
        if (!letter) begin
            digit = 1'b1;
            case (code)
                8'h45: di = 4'd0;
                8'h16: di = 4'd1;
                8'h1E: di = 4'd2;
                8'h26: di = 4'd3;
                8'h25: di = 4'd4;
                8'h2E: di = 4'd5;
                8'h36: di = 4'd6;
                8'h3D: di = 4'd7;
                8'h3E: di = 4'd8;
                8'h46: di = 4'd9;
                default: digit = 1'b0;
            endcase
        end
        if (letter) begin
            r.ch = ASC_LC_A + {3'b000, li};
            if (shift) r.ch = r.ch - ASC_CASE;
        end else if (digit) begin
            r.ch = ASC_ZERO + {4'b0000, di};
        end else if (code == SC_SPACE) begin
            r.ch = ASC_SPACE;
        end else if (code == SC_BKSP) begin
            r.ch = ASC_BKSP;
        end else if (code == SC_ENTER) begin
            r.ch = ASC_CR;
        end else begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_source_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect, 11-bit frame
// shifter with odd-parity/stop check, and a mid-frame inactivity timeout.
module ps2_key_source_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_q;
    logic                   fall;
    logic                   din;
    logic [3:0]             cnt;
    logic [7:0]             shreg;
    logic                   par;
    logic [TW-1:0]          tcnt;

    // Lines idle high, so synchronisers reset to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_q    <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_q & ~clk_sync[SYNC_STAGES-1];
    assign din     = dat_sync[SYNC_STAGES-1];
    assign rx_byte = shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            shreg   <= 8'h00;
            par     <= 1'b0;
            tcnt    <= '0;
            byte_ok <= 1'b0;
            err     <= 1'b0;
        end else begin
            byte_ok <= 1'b0;
            err     <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (cnt == 4'd0) begin
                    if (!din) cnt <= 4'd1;
                end else if (cnt <= 4'd8) begin
                    shreg <= {din, shreg[7:1]};
                    cnt   <= cnt + 4'd1;
                end else if (cnt == 4'd9) begin
                    par <= din;
                    cnt <= 4'd10;
                end else begin
                    cnt <= 4'd0;
                    if (din && (^{shreg, par})) byte_ok <= 1'b1;
                    else                        err     <= 1'b1;
                end
            end else if (cnt != 4'd0) begin
                if (tcnt == T_LAST) begin
                    err  <= 1'b1;
                    cnt  <= 4'd0;
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_source.sv
// PS/2 keyboard front end: set-2 make/break/E0 decoder with shift tracking that strobes
// host_enable once per printable key press, with the ASCII held on data.
module ps2_key_source
    import ps2_key_source_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       host_enable,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       rx_err;
    logic [1:0] state;
    logic       shift;
    map_t       m;

    ps2_key_source_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk     (clk50),
        .rst     (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .byte_ok (byte_ok),
        .err     (rx_err)
    );

    assign m         = ascii_map(rx_byte, shift);
    // rx_err is already a registered one-cycle strobe, exclusive with byte_ok.
    assign frame_err = rx_err;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift       <= 1'b0;
            data        <= 8'h00;
            host_enable <= 1'b0;
            scan_code   <= 8'h00;
        end else begin
            host_enable <= 1'b0;
            if (byte_ok) begin
                scan_code <= rx_byte;
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == SC_BREAK) begin
                            state <= ST_BREAK;
                        end else if (rx_byte == SC_EXT) begin
                            state <= ST_EXT;
                        end else if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) begin
                            shift <= 1'b1;
                        end else if (m.hit) begin
                            data        <= m.ch;
                            host_enable <= 1'b1;
                        end
                    end
                    ST_EXT: begin
                        state <= (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_BREAK: begin
                        if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) shift <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_source.sv
// Directed bench for ps2_key_source: bit-banged PS/2 frames, hand-computed ASCII results.
`timescale 1ns/1ps
module tb_ps2_key_source;

    localparam int TOUT = 500;
    localparam int CYC  = 20;
    localparam int QTR  = 10 * CYC;
    localparam int HALF = 20 * CYC;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       host_enable;
    logic [7:0] scan_code;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int he_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int he0, fe0;

    ps2_key_source #(.SYNC_STAGES(2), .TIMEOUT(TOUT)) dut (
        .clk50      (clk50),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .host_enable(host_enable),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    always #(CYC/2) clk50 = ~clk50;

    always @(posedge clk50) begin
        if (host_enable) he_cnt <= he_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (host_enable && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        #(QTR);
        ps2_clk = 1'b0;
        #(HALF);
        ps2_clk = 1'b1;
        #(QTR);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        #(HALF);
    endtask

    task automatic mark();
        he0 = he_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        #(5 * CYC + 3);
        chk("rst_data", data, 8'h00);
        chk("rst_he", host_enable, 0);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        #(10 * CYC);

        // 1: plain 'a'
        mark();
        send_frame(8'h1C, 1'b0);
        chk("t1_pulses", he_cnt - he0, 1);
        chk("t1_data", data, 8'h61);
        chk("t1_scan", scan_code, 8'h1C);
        chk("t1_ferr", fe_cnt - fe0, 0);

        // 2: shifted 'A', breaks emit nothing, shift released
        mark();
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        chk("t2_pulses", he_cnt - he0, 1);
        chk("t2_data", data, 8'h41);
        chk("t2_scan", scan_code, 8'h12);
        mark();
        send_frame(8'h1C, 1'b0);
        chk("t2_unshift", data, 8'h61);
        chk("t2_pulses2", he_cnt - he0, 1);

        // 3: parity error
        mark();
        send_frame(8'h1C, 1'b1);
        chk("t3_ferr", fe_cnt - fe0, 1);
        chk("t3_pulses", he_cnt - he0, 0);
        chk("t3_data", data, 8'h61);
        chk("t3_scan", scan_code, 8'h1C);

        // 4: timeout mid-frame, then space
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #(400 * CYC);
        chk("t4_early", fe_cnt - fe0, 0);
        #(200 * CYC);
        chk("t4_tout", fe_cnt - fe0, 1);
        chk("t4_pulses", he_cnt - he0, 0);
        mark();
        send_frame(8'h29, 1'b0);
        chk("t4_space", data, 8'h20);
        chk("t4_pulses2", he_cnt - he0, 1);

        // 5: extended keys suppressed, then '1'
        mark();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        chk("t5_nopulse", he_cnt - he0, 0);
        chk("t5_data", data, 8'h20);
        mark();
        send_frame(8'h16, 1'b0);
        chk("t5_one", data, 8'h31);
        chk("t5_pulses", he_cnt - he0, 1);

        // extras: typematic, right shift, shifted digit, backspace
        mark();
        send_frame(8'h59, 1'b0);
        send_frame(8'h2B, 1'b0);
        send_frame(8'h2B, 1'b0);
        chk("x_typematic", he_cnt - he0, 2);
        chk("x_rshift_F", data, 8'h46);
        send_frame(8'h16, 1'b0);
        chk("x_shift_digit", data, 8'h31);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h59, 1'b0);
        send_frame(8'h1A, 1'b0);
        chk("x_z", data, 8'h7A);
        send_frame(8'h66, 1'b0);
        chk("x_bksp", data, 8'h08);
        send_frame(8'h0E, 1'b0);
        chk("x_unmapped", data, 8'h08);
        chk("x_count", he_cnt - he0, 5);

        // 6: reset mid-frame, then enter
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        reset = 1'b1;
        #(3 * CYC);
        chk("t6_data", data, 8'h00);
        chk("t6_scan", scan_code, 8'h00);
        chk("t6_he", host_enable, 0);
        chk("t6_ferr", frame_err, 0);
        #(5 * CYC);
        reset = 1'b0;
        #(10 * CYC);
        mark();
        send_frame(8'h5A, 1'b0);
        chk("t6_enter", data, 8'h0D);
        chk("t6_scan2", scan_code, 8'h5A);
        chk("t6_pulses", he_cnt - he0, 1);
        chk("t6_ferr2", fe_cnt - fe0, 0);

        chk("never_both", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
